// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } md_state_e;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_Q  = '1;
    localparam logic [31:0] SMIN    = 32'h8000_0000;

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/response bundle between register file, core and muldiv_unit
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, kill, funct3, rs1, rs2, rd_in,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, kill, funct3, rs1, rs2, rd_in,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/muldiv_signfix.sv
// rtl/muldiv_signfix.sv - conditional two's-complement negation (magnitude / sign restore)
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         neg,
    output logic [W-1:0] mag
);
    assign mag = neg ? ({W{1'b0}} - value) : value;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, 32 iterations per operation
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    localparam logic [4:0] CNT_INIT = 5'(MD_ITER - 1);

    md_state_e         state, state_next;
    logic [4:0]        cnt;
    md_op_e            op_q;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   b_mag_q;
    logic [2*XLEN-1:0] acc;
    logic              res_neg;

    logic              busy_q, done_q;
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_out_q;

    // Operand entry: classify the op and take magnitudes
    md_op_e          op_in;
    logic            a_signed, b_signed, neg_a, neg_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div_in, is_rem_in, div_zero, div_ovf, fast, accept;

    always_comb begin
        op_in     = md_op_e'(bus.funct3);
        a_signed  = (op_in == OP_MUL) || (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                    (op_in == OP_DIV) || (op_in == OP_REM);
        b_signed  = (op_in == OP_MUL) || (op_in == OP_MULH) ||
                    (op_in == OP_DIV) || (op_in == OP_REM);
        neg_a     = a_signed & bus.rs1[XLEN-1];
        neg_b     = b_signed & bus.rs2[XLEN-1];
        is_div_in = bus.funct3[2];
        is_rem_in = (op_in == OP_REM) || (op_in == OP_REMU);
        div_zero  = (bus.rs2 == '0);
        div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                    (bus.rs1 == SMIN) && (bus.rs2 == '1);
        fast      = is_div_in & (div_zero | div_ovf);
        accept    = (state == IDLE) & bus.start & ~bus.kill;
    end

    muldiv_signfix #(.W(XLEN)) u_mag_a (.value(bus.rs1), .neg(neg_a), .mag(a_mag));
    muldiv_signfix #(.W(XLEN)) u_mag_b (.value(bus.rs2), .neg(neg_b), .mag(b_mag));

    // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next;
    logic              div_ge;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : '0);
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        div_ge    = ~div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};
    end

    // Result fixup: full 64-bit negate for multiplies, selected word for divides
    logic              is_rem_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   div_word, word_fix, fin_result;

    assign is_rem_q = (op_q == OP_REM) || (op_q == OP_REMU);
    assign div_word = is_rem_q ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];

    muldiv_signfix #(.W(2*XLEN)) u_fix_prod (.value(acc),      .neg(res_neg), .mag(prod_fix));
    muldiv_signfix #(.W(XLEN))   u_fix_word (.value(div_word), .neg(res_neg), .mag(word_fix));

    always_comb begin
        fin_result = '0;
        case (op_q)
            OP_MUL:                        fin_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_result = prod_fix[2*XLEN-1:XLEN];
            default:                       fin_result = word_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = fast ? FIN : CALC;
            CALC:    if (cnt == '0) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.kill) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            b_mag_q  <= '0;
            acc      <= '0;
            res_neg  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else begin
            busy_q <= (state_next != IDLE);
            done_q <= (state == FIN) && !bus.kill;
            if (accept) begin
                op_q    <= op_in;
                rd_q    <= bus.rd_in;
                b_mag_q <= b_mag;
                cnt     <= CNT_INIT;
                if (fast) begin
                    res_neg <= 1'b0;
                    if (div_zero) begin
                        acc <= is_rem_in ? {bus.rs1, {XLEN{1'b0}}} : {{XLEN{1'b0}}, DIV0_Q};
                    end else begin
                        acc <= is_rem_in ? '0 : {{XLEN{1'b0}}, SMIN};
                    end
                end else begin
                    acc     <= {{XLEN{1'b0}}, a_mag};
                    res_neg <= is_rem_in ? neg_a : (neg_a ^ neg_b);
                end
            end else if (state == CALC) begin
                acc <= op_q[2] ? div_next : mul_next;
                if (cnt != '0) cnt <= cnt - 5'd1;
            end else if (state == FIN && !bus.kill) begin
                result_q <= fin_result;
                rd_out_q <= rd_q;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the Otter core. It sits between register-file read and write-back. It consumes the `rs1`/`rs2` operands read from the register file plus the destination index, computes one M-extension operation over multiple cycles, and returns the 32-bit result with its destination index for the register-file write port (`w_data`/`w_adr`/`en`). It stalls the core via `busy` while an operation is in flight.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when `busy`=0.
- `kill`  in  1  synchronous flush (pipeline redirect); abandons any operation.
- `funct3`  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  32  operands from the register-file read ports.
- `rd_in`  in  5  destination register index.
- `busy`  out  1  operation accepted and not yet completed.
- `done`  out  1  one-cycle pulse; `result`/`rd_out` are valid in that cycle.
- `result`  out  32  operation result; holds its value until the next `done`.
- `rd_out`  out  5  destination index for the result; drives `w_adr`, and `done` drives `en`.

## Operation
- States: IDLE, CALC, FIN.
- IDLE: when `start`=1 and `kill`=0, latch `funct3` and `rd_in`, and take operand magnitudes plus result sign.
  - Signedness: MUL/MULH/DIV/REM use signed rs1 and rs2; MULHSU uses signed rs1 and unsigned rs2; others are unsigned.
  - Normal case: go to CALC with the counter at 31.
  - Fast path, straight to FIN with no CALC:
    - Divide by zero (rs2=0): DIV/DIVU give 0xFFFFFFFF; REM/REMU give rs1.
    - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle, 32 cycles total, counter 31→0.
  - Multiply: shift-add into a 64-bit unsigned product.
  - Divide: restoring, one quotient bit per cycle; 32-bit remainder, with a 33-bit subtract.
  - Leave CALC when the counter reaches 0.
- FIN: apply sign fixup, register `result`/`rd_out`, pulse `done`, return to IDLE.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32] after two's-complement negation of the full 64 bits when the sign is negative.
  - Quotient sign is rs1 XOR rs2 (signed ops); remainder sign follows rs1.
- `start` while `busy`=1 is ignored. There is no queueing; the core must hold the instruction.
- `kill`=1 in any state: go to IDLE next cycle with `busy`=0 and no `done`; `result` is unchanged.
  - `kill` and `start` together in IDLE: `kill` wins and nothing is accepted.
- All arithmetic wraps modulo 2^XLEN except the internal 64-bit product.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `rd_out`=0, state IDLE, counter 0.
- `busy` is registered. It rises the cycle after acceptance and falls in the same cycle that `done` is high.
- Normal latency: `start` accepted at edge T0 → `done` high in the cycle after edge T0+33 (1 entry cycle, 32 CALC cycles, 1 FIN cycle).
- Fast-path latency: `done` high in the cycle after edge T0+1.
- Back-to-back: a new `start` may be accepted on the edge where `done` is high, i.e. the cycle after FIN.
- Reset asserted mid-operation: outputs return to reset values immediately (asynchronous), with no `done`.

## Structure
- Package `muldiv_pkg` holds:
  - enum `md_op_e` for the `funct3` encodings above;
  - enum `md_state_e` {IDLE, CALC, FIN};
  - constants `MD_ITER=32`, `DIV0_Q='1`, `SMIN=32'h8000_0000`.
- One sub-module: `muldiv_signfix`, a combinational helper for magnitude/negation, used at both operand entry and result fixup.
- FSM, counter and datapath registers live in `muldiv_unit`.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → `result`=0xFFFFFFEB, `rd_out`=`rd_in`; `done` exactly 34 cycles after `start`; `busy` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 100/0 → 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0. Each has `done` 2 cycles after `start`.
- Pulse `kill` at CALC cycle 10 → no `done`, `busy`=0 next cycle, `result` keeps its prior value; a following MUL 3×5 → 15 with normal latency.
- Assert `rst_n`=0 mid-CALC → `busy`, `done`, `result` and `rd_out` go to 0 without waiting for a clock edge. `start` pulsed while `busy` is ignored: the first operation's result is delivered unaltered.
